// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath constants
package cpu_pkg;
    localparam int WIDTH  = 32;
    localparam int REG_AW = 5;
endpackage

// File: rtl/reg_file.sv
// reg_file: 32 x WIDTH register file, two async read ports, one sync write port, x0 hardwired to zero
module reg_file
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH,
    parameter int NREGS = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [WIDTH-1:0]  wd_i,
    output logic [WIDTH-1:0]  rs1_o,
    output logic [WIDTH-1:0]  rs2_o
);
    logic [WIDTH-1:0] regs_q [1:NREGS-1];
    logic [WIDTH-1:0] regs_d [1:NREGS-1];

    // write decode: only x1..x31 exist, so a write to x0 matches nothing
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NREGS; i++)
            if (we_i && rd_i == i[REG_AW-1:0]) regs_d[i] = wd_i;
    end

    // storage update; reset wins over a simultaneous write
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
        else
            regs_q <= regs_d;
    end

    // read muxes: no write forwarding, address 0 falls through to zero
    always_comb begin
        rs1_o = '0;
        rs2_o = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (rs1_i == i[REG_AW-1:0]) rs1_o = regs_q[i];
            if (rs2_i == i[REG_AW-1:0]) rs2_o = regs_q[i];
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scoreboard bench for reg_file
module tb_reg_file;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  rs1_i = '0, rs2_i = '0, rd_i = '0;
    logic [31:0] wd_i = '0;
    logic [31:0] rs1_o, rs2_o;
    logic [31:0] exp_q [$];
    int          passed = 0;
    int          total = 0;

    reg_file dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .we_i(we_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .wd_i(wd_i),
        .rs1_o(rs1_o), .rs2_o(rs2_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic compare(input logic [31:0] obs, input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        total++;
        assert (obs === e) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    endtask

    task automatic expect_read(input logic [4:0] a1, input logic [4:0] a2,
                               input logic [31:0] e1, input logic [31:0] e2, input string tag);
        rs1_i = a1;
        rs2_i = a2;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        #1;
        compare(rs1_o, $sformatf("%s_rs1_x%0d", tag, a1));
        compare(rs2_o, $sformatf("%s_rs2_x%0d", tag, a2));
    endtask

    task automatic write(input logic we, input logic [4:0] rd, input logic [31:0] wd);
        @(negedge clk_i);
        we_i = we;
        rd_i = rd;
        wd_i = wd;
        @(posedge clk_i);
        #1;
        we_i = 1'b0;
    endtask

    initial begin
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        for (int a = 0; a < 32; a++) expect_read(5'(a), 5'(31 - a), 32'h0, 32'h0, "reset");
        write(1'b1, 5'd0, 32'hFFFFFFFF);
        expect_read(5'd0, 5'd0, 32'h0, 32'h0, "x0_write");
        write(1'b1, 5'd1, 32'h11111111);
        write(1'b1, 5'd2, 32'h22222222);
        write(1'b0, 5'd3, 32'hAAAAAAAA);
        write(1'b0, 5'd1, 32'hAAAAAAAA);
        expect_read(5'd3, 5'd1, 32'h0, 32'h11111111, "we0");
        expect_read(5'd2, 5'd1, 32'h22222222, 32'h11111111, "basic");
        write(1'b1, 5'd4, 32'h44444444);
        write(1'b1, 5'd5, 32'h55555555);
        expect_read(5'd4, 5'd5, 32'h44444444, 32'h55555555, "b2b");
        expect_read(5'd5, 5'd4, 32'h55555555, 32'h44444444, "b2b_swap");
        write(1'b1, 5'd6, 32'h60606060);
        @(negedge clk_i);
        we_i = 1'b1;
        rd_i = 5'd6;
        wd_i = 32'h66666666;
        expect_read(5'd6, 5'd6, 32'h60606060, 32'h60606060, "pre_edge");
        @(posedge clk_i);
        #1;
        we_i = 1'b0;
        expect_read(5'd6, 5'd6, 32'h66666666, 32'h66666666, "post_edge");
        write(1'b1, 5'd6, 32'h77777777);
        write(1'b1, 5'd6, 32'h88888888);
        expect_read(5'd6, 5'd2, 32'h88888888, 32'h22222222, "last_wins");
        @(negedge clk_i);
        rst_n_i = 1'b0;
        we_i = 1'b1;
        rd_i = 5'd7;
        wd_i = 32'hDEADBEEF;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        we_i = 1'b0;
        for (int a = 0; a < 32; a++) expect_read(5'(a), 5'(a), 32'h0, 32'h0, "midreset");
        for (int i = 1; i <= 8; i++) write(1'b1, 5'(i), 32'hFFFFFFF7 + 32'(i));
        for (int i = 1; i <= 8; i++)
            expect_read(5'(i), 5'(9 - i), 32'hFFFFFFF7 + 32'(i), 32'hFFFFFFF7 + 32'(9 - i), "sweep");
        expect_read(5'd9, 5'd0, 32'h0, 32'h0, "sweep_edge");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
